// File: rtl/pueo_mode1_pkg.sv
// -----------------------------------------------------------------------------
// pueo_mode1_pkg
// Shared types and constants for the mode1 command packet buffer.
//   wr_state_t             : write-side packet FSM state
//   MODE1_MAX_LEN_DEFAULT  : default maximum packet length in bytes (inclusive)
//   MODE1_DROP_W           : width of the saturating drop counter
// -----------------------------------------------------------------------------
package pueo_mode1_pkg;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_FILL    = 2'd1,
    WR_DISCARD = 2'd2
  } wr_state_t;

  localparam int MODE1_MAX_LEN_DEFAULT = 256;
  localparam int MODE1_DROP_W          = 16;

endpackage

// File: rtl/pueo_mode1_pkt_buffer_ram.sv
// -----------------------------------------------------------------------------
// pueo_mode1_pkt_ram
// Simple dual-port RAM, one write port and one registered read port.
// Ports:
//   i_clk      : clock
//   i_wr_en    : write strobe
//   i_wr_addr  : write address
//   i_wr_data  : write data
//   i_rd_en    : read strobe; o_rd_data updates one clock later
//   i_rd_addr  : read address
//   o_rd_data  : registered read data
// -----------------------------------------------------------------------------
module pueo_mode1_pkt_ram #(
  parameter int DEPTH_LOG2 = 9,
  parameter int WIDTH      = 9
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [DEPTH_LOG2-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic                  i_rd_en,
  input  logic [DEPTH_LOG2-1:0] i_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data
);

  logic [WIDTH-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pueo_mode1_pkt_buffer.sv
// -----------------------------------------------------------------------------
// pueo_mode1_pkt_buffer
// Buffers mode1 command packets from a no-backpressure byte source, commits a
// packet only on tlast, drops oversize/overflowing (and optionally bad-checksum)
// packets, and replays committed packets as an AXI4-Stream master.
// Optional feature macro: PUEO_MODE1_CHECKSUM_EN (8-bit zero-sum check).
// Ports:
//   sysclk_i       : clock
//   rst_i          : synchronous active-high reset (wins over cmdproc_rst_i)
//   cmdproc_rst_i  : soft flush of buffer contents (drop counter kept)
//   s_tdata/s_tvalid/s_tlast : input byte stream, no backpressure
//   m_tdata/m_tvalid/m_tlast/m_tready : output AXI4-Stream master
//   pkt_count_o    : committed packets not yet fully read
//   drop_count_o   : saturating count of dropped packets
// -----------------------------------------------------------------------------
module pueo_mode1_pkt_buffer
  import pueo_mode1_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int MAX_LEN    = MODE1_MAX_LEN_DEFAULT
) (
  input  logic                    sysclk_i,
  input  logic                    rst_i,
  input  logic                    cmdproc_rst_i,
  input  logic [7:0]              s_tdata,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic [7:0]              m_tdata,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  input  logic                    m_tready,
  output logic [DEPTH_LOG2:0]     pkt_count_o,
  output logic [MODE1_DROP_W-1:0] drop_count_o
);

  localparam int                LEN_W     = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_LEN);

  function automatic logic [MODE1_DROP_W-1:0] sat_inc(input logic [MODE1_DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  wr_state_t               r_state;
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2-1:0]   r_wr_commit;
  logic [DEPTH_LOG2-1:0]   r_rd_ptr;
  logic [LEN_W-1:0]        r_len;
  logic [DEPTH_LOG2:0]     r_pkt_count;
  logic [MODE1_DROP_W-1:0] r_drop_count;
  logic                    r_vld_p1;
  logic [1:0]              r_cnt_p2;
  logic [8:0]              r_buf0_p2;
  logic [8:0]              r_buf1_p2;

  logic [DEPTH_LOG2-1:0]   w_wr_ptr_nxt;
  logic                    w_full;
  logic                    w_room;
  logic                    w_accept;
  logic                    w_pkt_ok;
  logic                    w_commit;
  logic                    w_drop;
  logic                    w_pop;
  logic [1:0]              w_occ;
  logic                    w_issue;
  logic [8:0]              w_ram_q;

  assign w_wr_ptr_nxt = r_wr_ptr + 1'b1;
  assign w_full       = (w_wr_ptr_nxt == r_rd_ptr);
  assign w_room       = (r_len < MAX_LEN_L);
  assign w_accept     = s_tvalid && (r_state != WR_DISCARD) && !w_full && w_room;

`ifdef PUEO_MODE1_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] w_sum_nxt;
  assign w_sum_nxt = r_sum + s_tdata;
  // The last byte is the checksum itself, so the packet must hold at least
  // one payload byte before it.
  assign w_pkt_ok  = (w_sum_nxt == 8'h00) && (r_len != '0);
`else
  assign w_pkt_ok  = 1'b1;
`endif

  assign w_commit = w_accept && s_tlast && w_pkt_ok;
  assign w_drop   = s_tvalid && s_tlast && !w_commit;

  // Stage p0: write FSM and speculative write pointer
  always_ff @(posedge sysclk_i) begin
    if (rst_i || cmdproc_rst_i) begin
      r_state     <= WR_IDLE;
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_len       <= '0;
`ifdef PUEO_MODE1_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else if (s_tvalid) begin
      if (s_tlast) begin
        r_state <= WR_IDLE;
        r_len   <= '0;
`ifdef PUEO_MODE1_CHECKSUM_EN
        r_sum   <= '0;
`endif
        if (w_commit) begin
          r_wr_ptr    <= w_wr_ptr_nxt;
          r_wr_commit <= w_wr_ptr_nxt;
        end else begin
          r_wr_ptr    <= r_wr_commit;
        end
      end else if (w_accept) begin
        r_state  <= WR_FILL;
        r_wr_ptr <= w_wr_ptr_nxt;
        r_len    <= r_len + 1'b1;
`ifdef PUEO_MODE1_CHECKSUM_EN
        r_sum    <= w_sum_nxt;
`endif
      end else begin
        r_state  <= WR_DISCARD;
      end
    end
  end

  always_ff @(posedge sysclk_i) begin
    if (rst_i) r_drop_count <= '0;
    else if (!cmdproc_rst_i && w_drop) r_drop_count <= sat_inc(r_drop_count);
  end

  pueo_mode1_pkt_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (9)
  ) u_ram (
    .i_clk      (sysclk_i),
    .i_wr_en    (w_accept && !cmdproc_rst_i && !rst_i),
    .i_wr_addr  (r_wr_ptr),
    .i_wr_data  ({s_tlast, s_tdata}),
    .i_rd_en    (w_issue),
    .i_rd_addr  (r_rd_ptr),
    .o_rd_data  (w_ram_q)
  );

  // Prefetch is capped at two entries (skid slots plus the RAM read in flight)
  // so only two freed bytes ever move out of the RAM while the consumer stalls.
  assign w_pop   = (r_cnt_p2 != 2'd0) && m_tready;
  assign w_occ   = r_cnt_p2 + {1'b0, r_vld_p1};
  assign w_issue = (r_rd_ptr != r_wr_commit) && ((w_occ < 2'd2) || w_pop);

  // Stage p1: RAM read issue, registered read data valid next clock
  always_ff @(posedge sysclk_i) begin
    if (rst_i || cmdproc_rst_i) begin
      r_rd_ptr <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_issue;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Stage p2: two-entry skid buffer, r_buf0_p2 drives the output
  always_ff @(posedge sysclk_i) begin
    if (rst_i || cmdproc_rst_i) begin
      r_cnt_p2 <= 2'd0;
    end else begin
      case ({w_pop, r_vld_p1})
        2'b10:   r_cnt_p2 <= r_cnt_p2 - 2'd1;
        2'b01:   r_cnt_p2 <= r_cnt_p2 + 2'd1;
        default: r_cnt_p2 <= r_cnt_p2;
      endcase
    end
  end

  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      r_buf0_p2 <= '0;
    end else begin
      case ({w_pop, r_vld_p1})
        2'b11: begin
          if (r_cnt_p2 == 2'd1) begin
            r_buf0_p2 <= w_ram_q;
          end else begin
            r_buf0_p2 <= r_buf1_p2;
            r_buf1_p2 <= w_ram_q;
          end
        end
        2'b10: r_buf0_p2 <= r_buf1_p2;
        2'b01: begin
          if (r_cnt_p2 == 2'd0) r_buf0_p2 <= w_ram_q;
          else                  r_buf1_p2 <= w_ram_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sysclk_i) begin
    if (rst_i || cmdproc_rst_i) begin
      r_pkt_count <= '0;
    end else begin
      case ({w_commit, w_pop && r_buf0_p2[8]})
        2'b10:   r_pkt_count <= r_pkt_count + 1'b1;
        2'b01:   r_pkt_count <= r_pkt_count - 1'b1;
        default: r_pkt_count <= r_pkt_count;
      endcase
    end
  end

  assign m_tvalid     = (r_cnt_p2 != 2'd0);
  assign m_tdata      = r_buf0_p2[7:0];
  assign m_tlast      = r_buf0_p2[8];
  assign pkt_count_o  = r_pkt_count;
  assign drop_count_o = r_drop_count;

endmodule

// File: tb/tb_pueo_mode1_pkt_buffer.sv
module tb_pueo_mode1_pkt_buffer;

  localparam int DEPTH_LOG2 = 4;
  localparam int MAX_LEN    = 6;

  logic                  sysclk_i = 1'b0;
  logic                  rst_i;
  logic                  cmdproc_rst_i;
  logic [7:0]            s_tdata;
  logic                  s_tvalid;
  logic                  s_tlast;
  logic [7:0]            m_tdata;
  logic                  m_tvalid;
  logic                  m_tlast;
  logic                  m_tready;
  logic [DEPTH_LOG2:0]   pkt_count_o;
  logic [15:0]           drop_count_o;

  int         n_total = 0;
  int         n_bad   = 0;
  logic [8:0] rx_q[$];
  logic       hold_en;
  logic       prev_stall;
  logic [8:0] prev_beat;

  pueo_mode1_pkt_buffer #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .MAX_LEN    (MAX_LEN)
  ) dut (
    .sysclk_i      (sysclk_i),
    .rst_i         (rst_i),
    .cmdproc_rst_i (cmdproc_rst_i),
    .s_tdata       (s_tdata),
    .s_tvalid      (s_tvalid),
    .s_tlast       (s_tlast),
    .m_tdata       (m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tlast       (m_tlast),
    .m_tready      (m_tready),
    .pkt_count_o   (pkt_count_o),
    .drop_count_o  (drop_count_o)
  );

  always #5 sysclk_i = ~sysclk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Negedge sampling sees the values that the next posedge will transfer.
  always @(negedge sysclk_i) begin
    if (hold_en && prev_stall) begin
      chk("hold_vld", {31'd0, m_tvalid}, 32'd1);
      chk("hold_beat", {23'd0, m_tlast, m_tdata}, {23'd0, prev_beat});
    end
    prev_stall = m_tvalid && !m_tready;
    prev_beat  = {m_tlast, m_tdata};
    if (m_tvalid && m_tready) rx_q.push_back({m_tlast, m_tdata});
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge sysclk_i);
    #1;
  endtask

  // bytes are packed first-byte-in-LSB
  task automatic send(input logic [63:0] bytes, input int n, input logic last);
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = bytes[8*i +: 8];
      s_tlast  = last && (i == n - 1);
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = 8'h00;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic chk_rx(input string tag, input logic [63:0] bytes, input int n, input int off);
    logic [31:0] got;
    for (int i = 0; i < n; i++) begin
      got = (off + i < rx_q.size()) ? {23'd0, rx_q[off+i]} : 32'hDEAD;
      chk($sformatf("%s_b%0d", tag, i), got, {23'd0, (i == n - 1), bytes[8*i +: 8]});
    end
  endtask

  initial begin
    rst_i = 1'b1; cmdproc_rst_i = 1'b0;
    s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0;
    m_tready = 1'b1; hold_en = 1'b1; prev_stall = 1'b0; prev_beat = '0;
    tick(3);
    chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_tdata",  {24'd0, m_tdata},  32'd0);
    chk("rst_tlast",  {31'd0, m_tlast},  32'd0);
    chk("rst_pkt",    {27'd0, pkt_count_o}, 32'd0);
    chk("rst_drop",   {16'd0, drop_count_o}, 32'd0);
    rst_i = 1'b0;
    tick();

    // single packet, latency and drain
    rx_q.delete();
    send(64'h0000_0000_00D0_2010, 3, 1'b1);
    chk("t1_pkt_commit", {27'd0, pkt_count_o}, 32'd1);
    chk("t1_vld_c0", {31'd0, m_tvalid}, 32'd0);
    tick();
    chk("t1_vld_c1", {31'd0, m_tvalid}, 32'd0);
    tick();
    chk("t1_vld_c2", {31'd0, m_tvalid}, 32'd1);
    chk("t1_first",  {24'd0, m_tdata}, 32'h10);
    wait_rx(3, 20);
    tick(2);
    chk("t1_rx_n", rx_q.size(), 32'd3);
    chk_rx("t1", 64'h0000_0000_00D0_2010, 3, 0);
    chk("t1_pkt_end",  {27'd0, pkt_count_o}, 32'd0);
    chk("t1_drop",     {16'd0, drop_count_o}, 32'd0);

    // oversize packet dropped, following packet passes
    rx_q.delete();
    send(64'h0007_0605_0403_0201, 7, 1'b1);
    chk("t2_drop", {16'd0, drop_count_o}, 32'd1);
    chk("t2_pkt0", {27'd0, pkt_count_o}, 32'd0);
    send(64'h0000_0000_0000_CD33, 2, 1'b1);
    wait_rx(2, 20);
    tick(3);
    chk("t2_rx_n", rx_q.size(), 32'd2);
    chk_rx("t2", 64'h0000_0000_0000_CD33, 2, 0);
    chk("t2_drop_end", {16'd0, drop_count_o}, 32'd1);

    // full buffer with a stalled consumer; MAX_LEN-sized packets accepted
    rx_q.delete();
    m_tready = 1'b0;
    send(64'h0000_F105_0403_0201, 6, 1'b1);
    send(64'h0000_1050_4030_2010, 6, 1'b1);
    send(64'h0000_AAAA_AAAA_AAAA, 6, 1'b1);
    tick(2);
    chk("t3_pkt",   {27'd0, pkt_count_o}, 32'd2);
    chk("t3_drop",  {16'd0, drop_count_o}, 32'd2);
    chk("t3_vld",   {31'd0, m_tvalid}, 32'd1);
    chk("t3_head",  {24'd0, m_tdata}, 32'h01);
    chk("t3_rx0",   rx_q.size(), 32'd0);
    m_tready = 1'b1;
    wait_rx(12, 40);
    tick(4);
    chk("t3_rx_n", rx_q.size(), 32'd12);
    chk_rx("t3a", 64'h0000_F105_0403_0201, 6, 0);
    chk_rx("t3b", 64'h0000_1050_4030_2010, 6, 6);
    chk("t3_pkt_end", {27'd0, pkt_count_o}, 32'd0);
    chk("t3_vld_end", {31'd0, m_tvalid}, 32'd0);

    // ready toggling every clock
    rx_q.delete();
    send(64'h0000_0000_9A33_2211, 4, 1'b1);
    for (int i = 0; i < 16; i++) begin
      m_tready = ~m_tready;
      tick();
    end
    m_tready = 1'b1;
    wait_rx(4, 20);
    tick(3);
    chk("t4_rx_n", rx_q.size(), 32'd4);
    chk_rx("t4", 64'h0000_0000_9A33_2211, 4, 0);
    chk("t4_pkt_end", {27'd0, pkt_count_o}, 32'd0);

    // flush with one committed packet and one partial packet pending
    rx_q.delete();
    m_tready = 1'b0;
    send(64'h0000_0000_0000_BC44, 2, 1'b1);
    send(64'h0000_0000_0000_6655, 2, 1'b0);
    tick(2);
    chk("t5_vld_pre", {31'd0, m_tvalid}, 32'd1);
    chk("t5_pkt_pre", {27'd0, pkt_count_o}, 32'd1);
    hold_en = 1'b0;
    cmdproc_rst_i = 1'b1;
    s_tvalid = 1'b1; s_tdata = 8'h99; s_tlast = 1'b1;
    tick();
    cmdproc_rst_i = 1'b0;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00;
    chk("t5_vld_post",  {31'd0, m_tvalid}, 32'd0);
    chk("t5_pkt_post",  {27'd0, pkt_count_o}, 32'd0);
    chk("t5_drop_post", {16'd0, drop_count_o}, 32'd2);
    tick();
    hold_en = 1'b1;
    m_tready = 1'b1;
    send(64'h0000_0000_0000_8977, 2, 1'b1);
    wait_rx(2, 20);
    tick(3);
    chk("t5_rx_n", rx_q.size(), 32'd2);
    chk_rx("t5", 64'h0000_0000_0000_8977, 2, 0);
    chk("t5_drop_end", {16'd0, drop_count_o}, 32'd2);

`ifdef PUEO_MODE1_CHECKSUM_EN
    // good sum passes, bad sum and lone zero byte dropped
    rx_q.delete();
    send(64'h0000_0000_0000_FF01, 2, 1'b1);
    send(64'h0000_0000_0000_FE01, 2, 1'b1);
    send(64'h0000_0000_0000_0000, 1, 1'b1);
    wait_rx(2, 20);
    tick(4);
    chk("t6_rx_n", rx_q.size(), 32'd2);
    chk_rx("t6", 64'h0000_0000_0000_FF01, 2, 0);
    chk("t6_drop", {16'd0, drop_count_o}, 32'd4);
    chk("t6_pkt",  {27'd0, pkt_count_o}, 32'd0);
`else
    // one-byte packet is a valid packet
    rx_q.delete();
    send(64'h0000_0000_0000_005A, 1, 1'b1);
    wait_rx(1, 20);
    tick(3);
    chk("t6_rx_n", rx_q.size(), 32'd1);
    chk_rx("t6", 64'h0000_0000_0000_005A, 1, 0);
    chk("t6_drop", {16'd0, drop_count_o}, 32'd2);
    chk("t6_pkt",  {27'd0, pkt_count_o}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
